inst_sram_responder: RTL and testbench

- Responder (slave) end of the sram-like req/addr_ok/data_ok protocol driven by the IF stage: accepts address handshakes, holds accepted requests in an in-order outstanding queue, and returns data_ok/rdata after a configurable latency.
- Backed by an internal word-addressed memory array.
- Serves as the simulation model for the instruction memory and as the building block for the later AXI bridge's inst-side slave port.

---
 rtl/inst_sram_responder_pkg.sv | 26 ++
 rtl/inst_sram_responder_if.sv | 22 ++
 rtl/inst_sram_resp_queue.sv | 99 +++++++++
 rtl/inst_sram_responder.sv | 83 ++++++++
 tb/tb_inst_sram_responder.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_sram_responder_pkg.sv
// Shared types and constants for the instruction-side sram-like responder.
// Holds size codes, queue entry layout and LFSR constants.
package inst_sram_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int RDATA_W = 32;
  // Wide enough for LATENCY-1 (max 14) plus up to 7 random extra cycles.
  localparam int AGE_W   = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [RDATA_W-1:0] rdata;
    logic [AGE_W-1:0]   age;
  } resp_entry_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/inst_sram_responder_if.sv
// sram-like req/addr_ok/data_ok bus between the IF stage and its memory responder.
interface inst_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/inst_sram_resp_queue.sv
// In-order outstanding-request FIFO; each entry carries its response word and
// a saturating age counter, and the head may complete once its age reaches 0.
module inst_sram_resp_queue
  import inst_sram_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  resp_entry_t        push_entry,
  input  logic               pop,
  output logic               full,
  output logic               head_ready,
  output logic [RDATA_W-1:0] head_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]       head_reg, head_next;
  logic [PTR_W-1:0]       tail_reg, tail_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [RDATA_W-1:0]     data_mem [DEPTH];
  logic [DEPTH*AGE_W-1:0] age_flat;
  logic [AGE_W-1:0]       head_age;
  logic                   do_push;
  logic                   do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A slot freed by this cycle's pop is not reusable until the next cycle.
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign head_age   = age_flat[head_reg*AGE_W +: AGE_W];
  assign head_ready = (count_reg != '0) && (head_age == '0);
  assign head_rdata = head_ready ? data_mem[head_reg] : '0;
  assign do_push    = push & ~full;
  assign do_pop     = pop & head_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AGE_W-1:0] age_reg;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          age_reg <= '0;
        end else if (do_push && (tail_reg == PTR_W'(gi))) begin
          age_reg <= push_entry.age;
        end else if (age_reg != '0) begin
          age_reg <= age_reg - AGE_W'(1);
        end
      end

      assign age_flat[gi*AGE_W +: AGE_W] = age_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[tail_reg] <= push_entry.rdata;
    end
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (do_push) begin
      tail_next = ptr_inc(tail_reg);
    end
    if (do_pop) begin
      head_next = ptr_inc(head_reg);
    end
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  count_bound: assert property (@(posedge clk) disable iff (!resetn)
                                count_reg <= CNT_W'(DEPTH));

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction memory responder for the sram-like bus: word array plus in-order queue.
// Optional INST_SRAM_RAND_DELAY_EN adds LFSR-driven addr_ok gaps and extra latency.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int OUTSTANDING = 4,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  inst_sram_responder_if.slave  bus
);

  localparam int MEM_DEPTH = 1 << MEM_AW;

  logic [31:0]        mem [MEM_DEPTH];
  logic [MEM_AW-1:0]  mem_idx;
  logic [31:0]        rd_word;
  logic               accept;
  logic               q_full;
  logic               head_ready;
  logic [RDATA_W-1:0] head_rdata;
  logic [AGE_W-1:0]   push_age;
  resp_entry_t        push_entry;
  logic               unused_bus;

  // Upper address bits alias; low bits and size are the initiator's concern.
  assign mem_idx    = bus.addr[MEM_AW+1:2];
  assign unused_bus = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

`ifdef INST_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign bus.addr_ok = resetn & ~q_full & ~lfsr_reg[0];
  assign push_age    = AGE_W'(LATENCY - 1) + AGE_W'(lfsr_reg[3:1]);
`else
  assign bus.addr_ok = resetn & ~q_full;
  assign push_age    = AGE_W'(LATENCY - 1);
`endif

  assign accept  = bus.req & bus.addr_ok;
  assign rd_word = mem[mem_idx];

  // Writes complete with a zero data word; reads capture the array at acceptance.
  assign push_entry.rdata = bus.wr ? '0 : rd_word;
  assign push_entry.age   = push_age;

  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[mem_idx][i*8 +: 8] <= bus.wdata[i*8 +: 8];
        end
      end
    end
  end

  inst_sram_resp_queue #(
    .DEPTH (OUTSTANDING)
  ) u_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (head_ready),
    .full       (q_full),
    .head_ready (head_ready),
    .head_rdata (head_rdata)
  );

  assign bus.data_ok = head_ready;
  assign bus.rdata   = head_rdata;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: a LATENCY=2 and a LATENCY=10 instance driven by a
// shared stimulus, checked against a queue/array reference model every cycle.
`timescale 1ns/1ps
module tb_inst_sram_responder;
  import inst_sram_responder_pkg::*;

  localparam int OUTS  = 4;
  localparam int LAT_F = 2;
  localparam int LAT_S = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = SIZE_WORD;
  logic [31:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;

  inst_sram_responder_if bus_f();
  inst_sram_responder_if bus_s();

  assign bus_f.req = req & ~sel;
  assign bus_s.req = req & sel;
  assign bus_f.wr = wr;       assign bus_s.wr = wr;
  assign bus_f.size = size;   assign bus_s.size = size;
  assign bus_f.addr = addr;   assign bus_s.addr = addr;
  assign bus_f.wstrb = wstrb; assign bus_s.wstrb = wstrb;
  assign bus_f.wdata = wdata; assign bus_s.wdata = wdata;

  inst_sram_responder #(.MEM_AW(12), .OUTSTANDING(OUTS), .LATENCY(LAT_F)) dut_f (
    .clk(clk), .resetn(resetn), .bus(bus_f));
  inst_sram_responder #(.MEM_AW(12), .OUTSTANDING(OUTS), .LATENCY(LAT_S)) dut_s (
    .clk(clk), .resetn(resetn), .bus(bus_s));

  wire        obs_aok = sel ? bus_s.addr_ok : bus_f.addr_ok;
  wire        obs_dok = sel ? bus_s.data_ok : bus_f.data_ok;
  wire [31:0] obs_rd  = sel ? bus_s.rdata   : bus_f.rdata;

  // Reference model: each response is due at max(accept+L, previous due+1).
  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t        exp_q[$];
  int          last_due = 0;
  logic [31:0] mem_f[int];
  logic [31:0] mem_s[int];
  logic [31:0] resp_log[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        acc = 1'b0;
  int          acc_cyc = 0;
  int          n_dok = 0;
  int          last_dok_cyc = 0;
  logic [31:0] last_rdata = '0;

  function automatic logic [31:0] mem_get(input int idx);
    if (sel) return mem_s.exists(idx) ? mem_s[idx] : 32'hxxxxxxxx;
    return mem_f.exists(idx) ? mem_f[idx] : 32'hxxxxxxxx;
  endfunction

  task automatic tick();
    int          lat, idx, due;
    logic        e_aok, e_dok;
    logic [31:0] e_rd, word;
    lat = sel ? LAT_S : LAT_F;
    @(negedge clk);
    e_aok = (exp_q.size() < OUTS);
    e_dok = (exp_q.size() != 0) && (exp_q[0].due == cyc);
    e_rd  = e_dok ? exp_q[0].data : 32'h0;
    n_cmp += 3;
    if (obs_aok !== e_aok) begin
      n_bad++; $display("FAIL addr_ok dut=%0d cyc=%0d got=%b exp=%b", sel, cyc, obs_aok, e_aok);
    end
    if (obs_dok !== e_dok) begin
      n_bad++; $display("FAIL data_ok dut=%0d cyc=%0d got=%b exp=%b", sel, cyc, obs_dok, e_dok);
    end
    if (obs_rd !== e_rd) begin
      n_bad++; $display("FAIL rdata dut=%0d cyc=%0d got=%h exp=%h", sel, cyc, obs_rd, e_rd);
    end
    if (obs_dok === 1'b1) begin
      n_dok++; last_dok_cyc = cyc; last_rdata = obs_rd; resp_log.push_back(obs_rd);
      $display("resp dut=%0d cyc=%0d rdata=%h", sel, cyc, obs_rd);
    end
    if (e_dok) void'(exp_q.pop_front());
    acc = req && e_aok;
    if (acc) begin
      idx = int'(addr[13:2]);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      acc_cyc  = cyc;
      if (wr) begin
        word = mem_get(idx);
        for (int i = 0; i < 4; i++) if (wstrb[i]) word[i*8 +: 8] = wdata[i*8 +: 8];
        if (sel) mem_s[idx] = word; else mem_f[idx] = word;
        exp_q.push_back('{data: 32'h0, due: due});
      end else begin
        exp_q.push_back('{data: mem_get(idx), due: due});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int n = 0;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    do begin tick(); n++; end while (!acc && n < 100);
    n_cmp++;
    if (!acc) begin n_bad++; $display("FAIL issue_timeout addr=%h got=no_accept exp=accept", a); end
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    req = 1'b1; wr = 1'b0; addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if ({bus_f.addr_ok, bus_f.data_ok, bus_f.rdata} !== 34'h0) begin
        n_bad++; $display("FAIL reset_fast got=%b/%b/%h exp=0/0/0", bus_f.addr_ok, bus_f.data_ok, bus_f.rdata);
      end
      if ({bus_s.addr_ok, bus_s.data_ok, bus_s.rdata} !== 34'h0) begin
        n_bad++; $display("FAIL reset_slow got=%b/%b/%h exp=0/0/0", bus_s.addr_ok, bus_s.data_ok, bus_s.rdata);
      end
    end
    @(posedge clk); #1;
    resetn = 1'b1; req = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_preload();
    sel = 1'b0;
    issue(1'b1, 32'h0000_0040, 4'hF, 32'h0280_0413);
    issue(1'b1, 32'h0000_0044, 4'hF, 32'h1122_3344);
    for (int i = 2; i < 8; i++) issue(1'b1, 32'h40 + 32'(4*i), 4'hF, $urandom());
    drain();
    sel = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b1, 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i));
    issue(1'b1, 32'h0000_0100, 4'hF, 32'h1001_0000);
    issue(1'b1, 32'h0000_0200, 4'hF, 32'h2002_0000);
    for (int i = 0; i < 8; i++) issue(1'b1, 32'h40 + 32'(4*i), 4'hF, $urandom());
    drain();
  endtask

  task automatic test_single_read();
    int a, d0;
    sel = 1'b0; d0 = n_dok;
    issue(1'b0, 32'h1c00_0040, 4'h0, 32'h0);
    a = acc_cyc;
    drain();
    n_cmp += 3;
    if (last_dok_cyc != a + 2) begin n_bad++; $display("FAIL single_read_cycle got=%0d exp=%0d", last_dok_cyc, a + 2); end
    if (last_rdata !== 32'h0280_0413) begin n_bad++; $display("FAIL single_read_data got=%h exp=02800413", last_rdata); end
    if (n_dok - d0 != 1) begin n_bad++; $display("FAIL single_read_count got=%0d exp=1", n_dok - d0); end
  endtask

  task automatic test_byte_lane();
    sel = 1'b0;
    issue(1'b1, 32'h0000_0044, 4'b0101, 32'hAABB_CCDD);
    issue(1'b0, 32'h0000_0044, 4'h0, 32'h0);
    drain();
    // Lanes 0 and 2 take DD and BB; lanes 1 and 3 keep 33 and 11.
    n_cmp++;
    if (last_rdata !== 32'h11BB_33DD) begin n_bad++; $display("FAIL byte_lane got=%h exp=11bb33dd", last_rdata); end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0, first = 0, d0;
    sel = 1'b0; d0 = n_dok;
    req = 1'b1; wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 32'h40 + 32'(4 * (i % 8));
      tick();
      if (acc) begin if (n_acc == 0) first = acc_cyc; n_acc++; end
    end
    drain();
    n_cmp += 3;
    if (n_acc != 16) begin n_bad++; $display("FAIL b2b_accepts got=%0d exp=16", n_acc); end
    if (n_dok - d0 != 16) begin n_bad++; $display("FAIL b2b_responses got=%0d exp=16", n_dok - d0); end
    if (last_dok_cyc != first + 17) begin n_bad++; $display("FAIL b2b_last_cycle got=%0d exp=%0d", last_dok_cyc, first + 17); end
  endtask

  task automatic test_full_queue();
    int n_acc = 0, first = 0, d0, n = 0;
    sel = 1'b1; d0 = n_dok; resp_log.delete();
    req = 1'b1; wr = 1'b0; addr = 32'h0;
    while (n_dok == d0 && n < 60) begin
      tick(); n++;
      if (acc) begin
        if (n_acc == 0) first = acc_cyc;
        n_acc++;
        addr = 32'(4 * n_acc);
      end
    end
    req = 1'b0;
    n_cmp += 2;
    if (n_acc != 4) begin n_bad++; $display("FAIL full_accepts got=%0d exp=4", n_acc); end
    if (last_dok_cyc != first + LAT_S) begin n_bad++; $display("FAIL full_first_resp got=%0d exp=%0d", last_dok_cyc, first + LAT_S); end
    drain();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (resp_log.size() <= i || resp_log[i] !== 32'hA000_0000 + 32'(i)) begin
        n_bad++; $display("FAIL full_order idx=%0d got=%h exp=%h", i,
                          (resp_log.size() > i) ? resp_log[i] : 32'hxxxxxxxx, 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_retarget();
    int n = 0;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h0, 4'h0, 32'h0);
    req = 1'b1; wr = 1'b0; addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (acc) begin n_bad++; $display("FAIL retarget_blocked step=%0d got=accept exp=blocked", i); end
    end
    addr = 32'h200;
    do begin tick(); n++; end while (!acc && n < 40);
    req = 1'b0;
    drain();
    n_cmp++;
    if (last_rdata !== 32'h2002_0000) begin n_bad++; $display("FAIL retarget_data got=%h exp=20020000", last_rdata); end
  endtask

  task automatic test_reset_midflight();
    int d0;
    sel = 1'b1;
    for (int i = 0; i < 3; i++) issue(1'b0, 32'h4, 4'h0, 32'h0);
    repeat (2) tick();
    d0 = n_dok;
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus_s.addr_ok, bus_s.data_ok, bus_s.rdata} !== 34'h0) begin
      n_bad++; $display("FAIL midflight_reset got=%b/%b/%h exp=0/0/0", bus_s.addr_ok, bus_s.data_ok, bus_s.rdata);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.delete(); last_due = 0;
    repeat (15) tick();
    n_cmp++;
    if (n_dok != d0) begin n_bad++; $display("FAIL midflight_stale_resp got=%0d exp=0", n_dok - d0); end
  endtask

  task automatic test_random(input logic which, input int cycles);
    int idx;
    sel = which;
    for (int i = 0; i < cycles; i++) begin
      idx   = 16 + int'($urandom_range(0, 7));
      req   = ($urandom_range(0, 9) < 7);
      wr    = ($urandom_range(0, 3) == 0);
      size  = 2'($urandom_range(0, 3));
      addr  = ($urandom() & 32'hFFFF_C000) | 32'(idx << 2) | ($urandom() & 32'h3);
      wstrb = 4'($urandom());
      wdata = $urandom();
      tick();
    end
    req = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_single_read();
    test_byte_lane();
    test_back_to_back();
    test_full_queue();
    test_retarget();
    test_reset_midflight();
    test_random(1'b0, 300);
    test_random(1'b1, 300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
